// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the host UART transmit and receive paths.
//   DATA_BITS               : payload bits per 8N1 frame
//   CLOCKS_PER_BAUD_DEFAULT : clk cycles per bit (12 MHz / 115200); used as
//                             the baud default in both directions
//   uart_tx_state_t         : transmit FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS               = 8;
   localparam int CLOCKS_PER_BAUD_DEFAULT = 104;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever rvalid is high; it is consumed on an edge with rvalid &&
// rready. DEPTH must be a power of two so the pointers wrap by overflow.
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   wdata/wvalid    : write data and request
//   wready          : registered !full; a write with wready low is dropped
//   rdata/rvalid    : head entry and non-empty flag
//   rready          : consume head entry
//   count           : number of entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       wvalid,
   output logic                       wready,
   output logic [WIDTH-1:0]           rdata,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             r_full;

   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_count_next;

   // Full is judged on the registered flag only, so a pop in the same cycle
   // never lets a write slip into a full FIFO.
   assign w_push = wvalid && !r_full;
   assign w_pop  = rready && (r_count != '0);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   assign wready = !r_full;
   assign rvalid = (r_count != '0);
   assign rdata  = r_mem[r_rptr];
   assign count  = r_count;

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter: bytes from the bus bridge are queued in a
// sync_fifo and serialized LSB first onto tx. Back-to-back frames are sent
// with no idle gap.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | line high, waiting for the FIFO to become non-empty
//   START | start bit (tx=0) for CLOCKS_PER_BAUD cycles
//   DATA  | data bit r_bit of r_shift, each CLOCKS_PER_BAUD cycles
//   STOP  | stop bit (tx=1); last cycle pops the next byte if one is queued
//
//   clk, rst  : clock, synchronous active-high reset (abandons any frame)
//   data_i    : byte to transmit
//   valid_i   : data_i valid; accepted on an edge where ready_o is high
//   ready_o   : FIFO not full (registered)
//   tx        : serial line, idle high, driven from a flop
//   busy_o    : FIFO non-empty or frame in progress (registered)
//   count_o   : bytes held in the FIFO, excluding the one being shifted
// ---------------------------------------------------------------------------
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_BAUD = CLOCKS_PER_BAUD_DEFAULT,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [7:0]                      data_i,
   input  logic                            valid_i,
   output logic                            ready_o,
   output logic                            tx,
   output logic                            busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

   localparam int BW  = $clog2(CLOCKS_PER_BAUD);
   localparam int IW  = $clog2(DATA_BITS);
   localparam int CW  = $clog2(FIFO_DEPTH+1);

   uart_tx_state_t   r_state;
   uart_tx_state_t   w_state_next;
   logic [BW-1:0]    r_baud;
   logic [BW-1:0]    w_baud_next;
   logic [IW-1:0]    r_bit;
   logic [IW-1:0]    w_bit_next;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_next;
   logic             r_tx;
   logic             w_tx_next;
   logic             r_busy;
   logic             w_busy_next;

   logic             w_pop;
   logic             w_push;
   logic             w_baud_done;
   logic             w_fifo_wready;
   logic             w_fifo_rvalid;
   logic [7:0]       w_fifo_rdata;
   logic [CW-1:0]    w_fifo_count;
   logic [CW-1:0]    w_count_next;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wdata  (data_i),
      .wvalid (valid_i),
      .wready (w_fifo_wready),
      .rdata  (w_fifo_rdata),
      .rvalid (w_fifo_rvalid),
      .rready (w_pop),
      .count  (w_fifo_count)
   );

   assign w_push      = valid_i && w_fifo_wready;
   assign w_baud_done = (r_baud == BW'(CLOCKS_PER_BAUD-1));

   // FIFO occupancy after this edge; lets busy_o be registered alongside
   // the state so it drops in the same cycle the FSM reaches IDLE.
   always_comb begin
      w_count_next = w_fifo_count;
      if (w_push && !w_pop) begin
         w_count_next = w_fifo_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = w_fifo_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_busy_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fifo_rvalid) begin
               w_pop        = 1'b1;
               w_shift_next = w_fifo_rdata;
               w_state_next = START;
               w_baud_next  = '0;
               w_bit_next   = '0;
            end
         end
         START: begin
            if (w_baud_done) begin
               w_state_next = DATA;
               w_baud_next  = '0;
               w_bit_next   = '0;
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         DATA: begin
            if (w_baud_done) begin
               w_baud_next = '0;
               if (r_bit == IW'(DATA_BITS-1)) begin
                  w_state_next = STOP;
               end else begin
                  w_bit_next = r_bit + IW'(1);
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         STOP: begin
            if (w_baud_done) begin
               w_baud_next = '0;
               if (w_fifo_rvalid) begin
                  w_pop        = 1'b1;
                  w_shift_next = w_fifo_rdata;
                  w_state_next = START;
                  w_bit_next   = '0;
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_baud_next = r_baud + BW'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
            w_baud_next  = '0;
            w_bit_next   = '0;
         end
      endcase
   end

   // Line level is decoded from the next state so the tx flop shows it in
   // the same cycle the state register does.
   always_comb begin
      w_tx_next   = 1'b1;
      w_busy_next = (w_state_next != IDLE) || (w_count_next != '0);
      case (w_state_next)
         START:   w_tx_next = 1'b0;
         DATA:    w_tx_next = w_shift_next[w_bit_next];
         default: w_tx_next = 1'b1;
      endcase
   end

   assign ready_o = w_fifo_wready;
   assign tx      = r_tx;
   assign busy_o  = r_busy;
   assign count_o = w_fifo_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    data_i;
   logic          valid_i;
   logic          ready_o;
   logic          tx;
   logic          busy_o;
   logic [CW-1:0] count_o;

   uart_tx_buffered #(
      .CLOCKS_PER_BAUD (CPB),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .tx      (tx),
      .busy_o  (busy_o),
      .count_o (count_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: queue of held bytes plus a frame timeline
   logic [7:0] q[$];
   logic [7:0] sb[$];
   bit         m_active  = 1'b0;
   int         m_elapsed = 0;
   logic [7:0] m_byte    = 8'h00;

   // independent line decoder
   bit         d_active = 1'b0;
   int         d_cnt    = 0;
   logic [7:0] d_byte   = 8'h00;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_tx();
      int e;
      if (!m_active) return 1;
      e = m_elapsed / CPB;
      if (e == 0) return 0;
      if (e <= 8) return int'(m_byte[e-1]);
      return 1;
   endfunction

   task automatic decode();
      int k;
      if (!d_active) begin
         if (tx === 1'b0) begin
            d_active = 1'b1;
            d_cnt    = 0;
            d_byte   = 8'h00;
         end
      end else begin
         d_cnt++;
         if (d_cnt < 9*CPB && d_cnt >= CPB + CPB/2 && ((d_cnt - CPB/2) % CPB) == 0) begin
            k = (d_cnt - CPB/2) / CPB - 1;
            d_byte[k] = tx;
         end
         if (d_cnt == 9*CPB + CPB/2) begin
            chk("stop_bit", int'(tx), 1);
            chk("dec_pending", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("dec_byte", int'(d_byte), int'(sb.pop_front()));
            d_active = 1'b0;
         end
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d);
      bit         acc;
      bit         last;
      rst     = r;
      valid_i = v;
      data_i  = d;
      acc     = !r && v && (q.size() < DEPTH);
      @(posedge clk);
      if (r) begin
         q.delete();
         sb.delete();
         m_active  = 1'b0;
         m_elapsed = 0;
         d_active  = 1'b0;
      end else begin
         last = m_active && (m_elapsed == FRAME-1);
         if ((!m_active || last) && q.size() > 0) begin
            m_byte    = q.pop_front();
            m_active  = 1'b1;
            m_elapsed = 0;
         end else if (m_active) begin
            m_elapsed++;
            if (m_elapsed == FRAME) m_active = 1'b0;
         end
         if (acc) begin
            q.push_back(d);
            sb.push_back(d);
         end
      end
      #1;
      chk("tx", int'(tx), m_tx());
      chk("busy", int'(busy_o), int'(m_active || q.size() != 0));
      chk("count", int'(count_o), q.size());
      chk("ready", int'(ready_o), int'(q.size() < DEPTH));
      if (!r) decode();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      rst     = 1'b1;
      valid_i = 1'b0;
      data_i  = 8'h00;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);

      // quiet line after reset
      idle(1000);

      // single byte
      step(1'b0, 1'b1, 8'h55);
      idle(FRAME + 5);

      // back-to-back pair
      step(1'b0, 1'b1, 8'hA3);
      step(1'b0, 1'b1, 8'h0F);
      idle(2*FRAME + 5);

      // overfill while a frame is active
      step(1'b0, 1'b1, 8'hEE);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i));
      idle(6*FRAME);

      // random streaming with gaps, heavy then light
      for (int i = 0; i < 1200; i++)
         step(1'b0, 1'($urandom_range(0, 99) < 12), 8'($urandom));
      for (int i = 0; i < 1200; i++)
         step(1'b0, 1'($urandom_range(0, 99) < 2), 8'($urandom));
      idle((DEPTH+2)*FRAME);

      // reset during data bit 3 with two bytes queued
      step(1'b0, 1'b1, 8'hFF);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      for (int i = 0; i < 200 && !(m_active && m_elapsed == 4*CPB + 1); i++)
         step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      idle(3*FRAME);
      step(1'b0, 1'b1, 8'h81);
      idle(FRAME + 5);

      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Transmit half of the host UART link: buffers response bytes from the on-chip bus bridge and serializes them onto the RS-232 TX line as 8N1 frames.
- Counterpart to the bridge's UART receiver; shares its baud parameterization so one value sets both directions.
- Decouples bursty bridge output (back-to-back read responses) from the slow serial line with a small FIFO.

Parameters:
- CLOCKS_PER_BAUD, 104, clk cycles per bit period (12 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, bytes of buffering; power of two, >= 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- data_i  input  8  byte to transmit
- valid_i  input  1  data_i valid
- ready_o  output  1  FIFO can accept; a transfer occurs on a rising edge when valid_i && ready_o
- tx  output  1  serial line, idle high
- busy_o  output  1  FIFO non-empty or frame in progress
- count_o  output  $clog2(FIFO_DEPTH+1)  bytes currently held in FIFO (excludes the byte being shifted)

Behaviour:
- Reset values: tx=1, ready_o=1, busy_o=0, count_o=0; FIFO empty; FSM in IDLE; baud counter and bit index cleared.
- Reset mid-frame: the frame is abandoned; tx=1 from the cycle after the reset edge; FIFO contents are discarded. No partial-frame completion.
- FIFO:
  - ready_o = !full, registered.
  - When full, ready_o=0 even if a pop occurs in the same cycle; no push-through-full.
  - Simultaneous push and pop when not full leaves count_o unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Writes with valid_i while ready_o=0 are ignored, not queued.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLOCKS_PER_BAUD cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[bit index], LSB first. Each bit is held CLOCKS_PER_BAUD cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLOCKS_PER_BAUD cycles. On the final stop cycle:
    - if the FIFO is non-empty, pop and go directly to START (no idle gap between frames);
    - else go to IDLE.
- Frame length is exactly 10*CLOCKS_PER_BAUD cycles.
- Latency: for a byte accepted at edge n into an empty FIFO with the FSM in IDLE, the FIFO is non-empty after edge n; the pop occurs at edge n+1; tx is first 0 in the cycle following edge n+1.
- tx is driven from a flop (glitch-free).
- busy_o = (state != IDLE) || (count_o != 0), registered consistently with the state; busy_o falls in the same cycle the FSM returns to IDLE.
- Baud counter counts 0..CLOCKS_PER_BAUD-1 and resets at each bit boundary. No fractional-baud accumulation.

Decomposition:
- Shared package uart_pkg:
  - typedef enum uart_tx_state_t {IDLE, START, DATA, STOP};
  - localparam DATA_BITS=8;
  - the default CLOCKS_PER_BAUD constant, also used by the receiver.
- Sub-module sync_fifo:
  - parameters WIDTH=8, DEPTH;
  - ports clk, rst, wdata, wvalid, wready, rdata, rvalid, rready, count;
  - first-word-fall-through; reusable by the receiver path.
- Top-level uart_tx_buffered instantiates sync_fifo plus the FSM and serializer.

Test Plan:
- Single byte, CLOCKS_PER_BAUD=4: push 0x55 -> tx low 4 cycles starting 2 cycles after the push, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. busy_o falls after 40 cycles of frame.
- Back-to-back: push 0xA3 and 0x0F on consecutive cycles -> two frames totaling exactly 80 cycles with no idle cycle between the stop bit of frame 1 and the start bit of frame 2. Decoded bytes are 0xA3, 0x0F.
- Full FIFO, FIFO_DEPTH=4: hold valid_i with bytes 0x00..0x07 while a frame is active:
  - ready_o drops when count_o=4;
  - refused bytes are not transmitted;
  - a monitor sees only accepted bytes, in order.
- Pointer wrap: stream 3*FIFO_DEPTH random bytes with random valid_i gaps -> a scoreboard UART decoder matches all bytes in order; count_o never exceeds FIFO_DEPTH.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF with 2 bytes queued -> tx=1 the next cycle, count_o=0, busy_o=0, ready_o=1; no further frames. Then push 0x81 -> a clean full frame.
- Idle line: no pushes for 1000 cycles after reset -> tx constant 1, busy_o=0.
